// File: rtl/sign_vector_reader.sv
// Snapshots DIM counter sign bits on capture and streams them as WORD-bit words.
// Optional SIGN_READER_POPCNT_EN appends a tail word holding the total count of ones.
module sign_vector_reader #(
   parameter int DIM  = 1024,
   parameter int WORD = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DIM-1:0]  sign_bits,
   input  logic            capture,
   output logic            out_valid,
   output logic [WORD-1:0] out_data,
   output logic            out_last,
   input  logic            out_ready,
   output logic            busy,
   output logic            done,
   output logic            capture_drop
);

   localparam int NWORDS = DIM / WORD;
   localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

`ifdef SIGN_READER_POPCNT_EN
   localparam int PW = $clog2(DIM + 1);
   typedef enum logic [1:0] {IDLE, SEND, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t          state;
   logic [DIM-1:0]  shadow;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   nxt_idx;
   logic            xfer;
   logic            nxt_last;

   assign xfer    = out_valid && out_ready;
   assign nxt_idx = idx + 1'b1;

`ifdef SIGN_READER_POPCNT_EN
   logic [PW-1:0] popcnt;
   logic [PW-1:0] pop_next;

   // Running total including the word currently on the bus.
   assign pop_next = popcnt + PW'($countones(out_data));
   assign nxt_last = 1'b0;
`else
   assign nxt_last = (nxt_idx == LAST_IDX);
`endif

   // Control FSM with registered stream outputs and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         shadow       <= '0;
         idx          <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         capture_drop <= 1'b0;
`ifdef SIGN_READER_POPCNT_EN
         popcnt       <= '0;
`endif
      end else begin
         done         <= 1'b0;
         capture_drop <= 1'b0;
         unique case (state)
            IDLE: begin
               if (capture) begin
                  state     <= SEND;
                  shadow    <= sign_bits;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  out_data  <= sign_bits[WORD-1:0];
`ifdef SIGN_READER_POPCNT_EN
                  out_last  <= 1'b0;
                  popcnt    <= '0;
`else
                  out_last  <= (NWORDS == 1);
`endif
               end
            end
            SEND: begin
               if (capture)
                  capture_drop <= 1'b1;
               if (xfer) begin
                  if (idx == LAST_IDX) begin
`ifdef SIGN_READER_POPCNT_EN
                     state    <= TAIL;
                     popcnt   <= pop_next;
                     out_data <= WORD'(pop_next);
                     out_last <= 1'b1;
`else
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
`endif
                  end else begin
                     idx      <= nxt_idx;
                     out_data <= shadow[nxt_idx*WORD +: WORD];
                     out_last <= nxt_last;
`ifdef SIGN_READER_POPCNT_EN
                     popcnt   <= pop_next;
`endif
                  end
               end
            end
`ifdef SIGN_READER_POPCNT_EN
            TAIL: begin
               if (capture)
                  capture_drop <= 1'b1;
               if (xfer) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sign_vector_reader.sv
// Scoreboard bench for sign_vector_reader at DIM=64, WORD=32.
// Honors SIGN_READER_POPCNT_EN when defined for the build.
module tb_sign_vector_reader;

   localparam int DIM  = 64;
   localparam int WORD = 32;
`ifdef SIGN_READER_POPCNT_EN
   localparam int NW_EXP = 3;
`else
   localparam int NW_EXP = 2;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [DIM-1:0]  sign_bits;
   logic            capture;
   logic            out_valid;
   logic [WORD-1:0] out_data;
   logic            out_last;
   logic            out_ready;
   logic            busy;
   logic            done;
   logic            capture_drop;

   int errors = 0;
   int checks = 0;
   int n_done = 0;
   int exp_done = 0;

   logic [32:0] q[$];

   sign_vector_reader #(.DIM(DIM), .WORD(WORD)) dut (
      .clk(clk),
      .rst(rst),
      .sign_bits(sign_bits),
      .capture(capture),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_last(out_last),
      .out_ready(out_ready),
      .busy(busy),
      .done(done),
      .capture_drop(capture_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_vec(input logic [63:0] v);
`ifdef SIGN_READER_POPCNT_EN
      logic [31:0] pc;
      pc = 32'($countones(v));
      q.push_back({1'b0, v[31:0]});
      q.push_back({1'b0, v[63:32]});
      q.push_back({1'b1, pc});
`else
      q.push_back({1'b0, v[31:0]});
      q.push_back({1'b1, v[63:32]});
`endif
      exp_done++;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30 && busy; i++) tick();
      chk("idle_wait", 64'(busy), 64'd0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30 && !done; i++) tick();
      chk("done_wait", 64'(done), 64'd1);
   endtask

   // Monitor: scoreboard pops on each transfer, stall stability checks.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         prev_stall = 1'b0;
      end else begin
         if (done) n_done++;
         if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(prev_data));
            chk("stall_last", 64'(out_last), 64'(prev_last));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word act=%0h req=none", out_data);
            end else begin
               logic [32:0] e;
               e = q.pop_front();
               chk("word_data", 64'(out_data), 64'(e[31:0]));
               chk("word_last", 64'(out_last), 64'(e[32]));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      capture   = 1'b0;
      sign_bits = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_drop", 64'(capture_drop), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      rst = 1'b0;
      tick();

      // Single vector, ready held high.
      sign_bits = 64'h0000_0001_8000_0000;
      capture   = 1'b1;
      push_vec(sign_bits);
      tick();
      capture = 1'b0;
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_data", 64'(out_data), 64'h8000_0000);
      for (int i = 0; i < NW_EXP; i++) begin
         chk("single_busy", 64'(busy), 64'd1);
         chk("single_nodone", 64'(done), 64'd0);
         tick();
      end
      chk("single_done", 64'(done), 64'd1);
      chk("single_idle", 64'(busy), 64'd0);
      chk("single_novalid", 64'(out_valid), 64'd0);
      tick();
      chk("done_pulse", 64'(done), 64'd0);

      // Backpressure pattern 0,0,1,0,1.
      out_ready = 1'b0;
      sign_bits = 64'h1234_5678_9ABC_DEF0;
      capture   = 1'b1;
      push_vec(sign_bits);
      tick();
      capture = 1'b0;
      out_ready = 1'b0; tick();
      out_ready = 1'b0; tick();
      out_ready = 1'b1; tick();
      out_ready = 1'b0; tick();
      out_ready = 1'b1; tick();
      out_ready = 1'b1;
      wait_idle();
      tick();

      // Snapshot isolation.
      sign_bits = 64'hFFFF_FFFF_0000_0000;
      capture   = 1'b1;
      push_vec(sign_bits);
      tick();
      capture   = 1'b0;
      sign_bits = '0;
      wait_idle();
      tick();

      // Capture one cycle after accept is dropped.
      sign_bits = 64'hA5A5_A5A5_5A5A_5A5A;
      capture   = 1'b1;
      push_vec(sign_bits);
      tick();
      sign_bits = 64'h1111_1111_2222_2222;
      tick();
      capture = 1'b0;
      chk("drop_pulse", 64'(capture_drop), 64'd1);
      tick();
      chk("drop_once", 64'(capture_drop), 64'd0);
      wait_done();

      // Capture on the done cycle is accepted.
      sign_bits = 64'hCAFE_F00D_DEAD_BEEF;
      capture   = 1'b1;
      push_vec(sign_bits);
      tick();
      capture = 1'b0;
      chk("done_cap_nodrop", 64'(capture_drop), 64'd0);
      chk("done_cap_busy", 64'(busy), 64'd1);
      for (int i = 0; i < NW_EXP - 1; i++) tick();

      // Capture during the final handshake is dropped.
      sign_bits = 64'h0F0F_0F0F_0F0F_0F0F;
      capture   = 1'b1;
      tick();
      capture = 1'b0;
      chk("final_hs_drop", 64'(capture_drop), 64'd1);
      chk("final_hs_done", 64'(done), 64'd1);
      tick();
      chk("final_hs_idle", 64'(busy), 64'd0);
      chk("final_hs_nodrop", 64'(capture_drop), 64'd0);

      // Reset after the first transfer.
      sign_bits = 64'h7777_7777_3333_3333;
      capture   = 1'b1;
      q.push_back({1'b0, 32'h3333_3333});
      tick();
      capture = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      tick();
      chk("mid_rst_nodone", 64'(done), 64'd0);
      sign_bits = 64'h0000_000F_0000_0003;
      capture   = 1'b1;
`ifdef SIGN_READER_POPCNT_EN
      q.push_back({1'b0, 32'h0000_0003});
      q.push_back({1'b0, 32'h0000_000F});
      q.push_back({1'b1, 32'd6});
`else
      q.push_back({1'b0, 32'h0000_0003});
      q.push_back({1'b1, 32'h0000_000F});
`endif
      exp_done++;
      tick();
      capture = 1'b0;
      chk("fresh_data", 64'(out_data), 64'h3);
      wait_idle();

      repeat (3) tick();
      chk("sb_drained", 64'(q.size()), 64'd0);
      chk("done_count", 64'(n_done), 64'(exp_done));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
